// File: rtl/iomem_width_bridge.sv
// Splits one BLK_SIZE-wide block request from the core into four XLEN-wide bus beats.
// Write beats whose byte strobes are all zero are skipped without driving the bus.
module iomem_width_bridge #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iomem_valid_i,
    output logic                iomem_ready_o,
    input  logic [XLEN-1:0]     iomem_addr_i,
    input  logic [15:0]         iomem_wstrb_i,
    input  logic [BLK_SIZE-1:0] iomem_wdata_i,
    output logic [BLK_SIZE-1:0] iomem_rdata_o,
    output logic                bus_valid_o,
    input  logic                bus_ready_i,
    output logic                bus_we_o,
    output logic [3:0]          bus_be_o,
    output logic [XLEN-1:0]     bus_addr_o,
    output logic [XLEN-1:0]     bus_wdata_o,
    input  logic [XLEN-1:0]     bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [15:0]           wstrb_q, wstrb_d;
    logic [BLK_SIZE-1:0]   wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [BLK_SIZE-1:0]   rdata_buf_q, rdata_buf_d;
    logic [3:0]            beat_be_s;
    logic                  skip_s;

    assign iomem_rdata_o = rdata_buf_q;

    // Byte enables of the current beat; a write beat with no enables is a skip.
    always_comb begin
        if (we_q) begin
            beat_be_s = wstrb_q[{beat_q, 2'b00} +: 4];
        end else begin
            beat_be_s = 4'hF;
        end
        skip_s = we_q && (beat_be_s == 4'h0);
    end

    // Next-state and output decode; bus outputs depend only on registered state.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        rdata_buf_d   = rdata_buf_q;
        iomem_ready_o = 1'b0;
        bus_valid_o   = 1'b0;
        bus_we_o      = 1'b0;
        bus_be_o      = 4'h0;
        bus_addr_o    = '0;
        bus_wdata_o   = '0;
        case (state_q)
            IDLE: begin
                if (iomem_valid_i) begin
                    addr_d  = iomem_addr_i;
                    wstrb_d = iomem_wstrb_i;
                    wdata_d = iomem_wdata_i;
                    we_d    = |iomem_wstrb_i;
                    beat_d  = 2'd0;
                    state_d = BEAT;
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT: begin
                bus_valid_o = !skip_s;
                bus_we_o    = we_q;
                bus_be_o    = beat_be_s;
                bus_addr_o  = {addr_q[XLEN-1:4], beat_q, 2'b00};
                bus_wdata_o = wdata_q[XLEN*int'(beat_q) +: XLEN];
                // bus_valid_o is !skip_s, so this is "handshake or skip".
                if (skip_s || bus_ready_i) begin
                    if (!we_q) begin
                        rdata_buf_d[XLEN*int'(beat_q) +: XLEN] = bus_rdata_i;
                    end else begin
                        rdata_buf_d = rdata_buf_q;
                    end
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    state_d = BEAT;
                end
            end
            DONE: begin
                iomem_ready_o = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            addr_q      <= '0;
            wstrb_q     <= 16'h0000;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

endmodule

// File: tb/tb_iomem_width_bridge.sv
// Self-checking bench for iomem_width_bridge: a per-cycle expectation queue built from
// the block-to-beat rules, checked on every falling edge, plus literal spot checks.
module tb_iomem_width_bridge;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         iomem_valid_i;
    logic         iomem_ready_o;
    logic [31:0]  iomem_addr_i;
    logic [15:0]  iomem_wstrb_i;
    logic [127:0] iomem_wdata_i;
    logic [127:0] iomem_rdata_o;
    logic         bus_valid_o;
    logic         bus_ready_i;
    logic         bus_we_o;
    logic [3:0]   bus_be_o;
    logic [31:0]  bus_addr_o;
    logic [31:0]  bus_wdata_o;
    logic [31:0]  bus_rdata_i;

    always #5 clk = ~clk;

    iomem_width_bridge #(.XLEN(32), .BLK_SIZE(128)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .iomem_valid_i (iomem_valid_i),
        .iomem_ready_o (iomem_ready_o),
        .iomem_addr_i  (iomem_addr_i),
        .iomem_wstrb_i (iomem_wstrb_i),
        .iomem_wdata_i (iomem_wdata_i),
        .iomem_rdata_o (iomem_rdata_o),
        .bus_valid_o   (bus_valid_o),
        .bus_ready_i   (bus_ready_i),
        .bus_we_o      (bus_we_o),
        .bus_be_o      (bus_be_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rdata_i   (bus_rdata_i)
    );

    localparam logic [1:0] M_ZERO = 2'd0;  // bus outputs must all be zero
    localparam logic [1:0] M_ACT  = 2'd1;  // active beat, all bus fields checked
    localparam logic [1:0] M_SKIP = 2'd2;  // skipped beat, only bus_valid_o checked

    typedef struct {
        logic         ready;
        logic         valid;
        logic [1:0]   mode;
        logic         we;
        logic [3:0]   be;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] model_buf;
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           ready_cyc = 0;
    int           ready_cnt = 0;
    logic [31:0]  obs_addr[$];
    logic [31:0]  obs_wdata[$];
    logic [3:0]   obs_be[$];
    logic         obs_we[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Compare process: one expectation per cycle, sampled on the falling edge.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("iomem_ready", {127'd0, iomem_ready_o}, {127'd0, e.ready});
            chk("bus_valid", {127'd0, bus_valid_o}, {127'd0, e.valid});
            if (e.mode != M_SKIP) begin
                chk("bus_we", {127'd0, bus_we_o}, {127'd0, e.we});
                chk("bus_be", {124'd0, bus_be_o}, {124'd0, e.be});
                chk("bus_addr", {96'd0, bus_addr_o}, {96'd0, e.addr});
                chk("bus_wdata", {96'd0, bus_wdata_o}, {96'd0, e.wdata});
            end
            chk("iomem_rdata", iomem_rdata_o, e.rdata);
        end
        if (bus_valid_o === 1'b1 && bus_ready_i === 1'b1) begin
            obs_addr.push_back(bus_addr_o);
            obs_wdata.push_back(bus_wdata_o);
            obs_be.push_back(bus_be_o);
            obs_we.push_back(bus_we_o);
        end
        if (iomem_ready_o === 1'b1) begin
            ready_cyc = cyc;
            ready_cnt++;
        end
    end

    // Inputs for the current cycle are already driven; queue what the outputs must be.
    task automatic step(input logic rdy, input logic vld, input logic [1:0] mode, input logic we,
                        input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.ready = rdy;
        e.valid = vld;
        e.mode  = mode;
        e.we    = we;
        e.be    = be;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = model_buf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, M_ZERO, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // One block request: accept cycle, four beats (stalls/skips), DONE pulse.
    task automatic run_req(input logic [31:0] addr, input logic [15:0] ws, input logic [127:0] wd,
                           input int st0, input int st1, input int st2, input int st3,
                           input logic [127:0] rd, input int abort_beat, output int acc);
        int          stl[4];
        logic        wr;
        logic [3:0]  be;
        logic [31:0] ba;
        stl = '{st0, st1, st2, st3};
        wr  = |ws;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = addr;
        iomem_wstrb_i = ws;
        iomem_wdata_i = wd;
        bus_ready_i   = 1'b0;
        acc = cyc;
        idle();
        iomem_addr_i  = ~addr;
        iomem_wstrb_i = ~ws;
        iomem_wdata_i = ~wd;
        for (int b = 0; b < 4; b++) begin
            be = wr ? ws[4*b +: 4] : 4'hF;
            ba = {addr[31:4], 4'h0} + 32'(4 * b);
            if (wr && be == 4'h0) begin
                bus_ready_i = 1'b1;
                bus_rdata_i = $urandom;
                step(1'b0, 1'b0, M_SKIP, 1'b0, 4'h0, 32'h0, 32'h0);
            end else begin
                for (int s = 0; s < stl[b]; s++) begin
                    bus_ready_i = 1'b0;
                    bus_rdata_i = $urandom;
                    step(1'b0, 1'b1, M_ACT, wr, be, ba, wd[32*b +: 32]);
                end
                if (b == abort_beat) begin
                    rst_i       = 1'b1;
                    bus_ready_i = 1'b0;
                    step(1'b0, 1'b1, M_ACT, wr, be, ba, wd[32*b +: 32]);
                    rst_i         = 1'b0;
                    iomem_valid_i = 1'b0;
                    model_buf     = 128'd0;
                    return;
                end
                bus_ready_i = 1'b1;
                bus_rdata_i = rd[32*b +: 32];
                step(1'b0, 1'b1, M_ACT, wr, be, ba, wd[32*b +: 32]);
                if (!wr) begin
                    model_buf[32*b +: 32] = rd[32*b +: 32];
                end
            end
        end
        bus_ready_i = 1'b1;
        step(1'b1, 1'b0, M_ZERO, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_ready_i   = 1'b0;
        iomem_valid_i = 1'b0;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_wdata.delete();
        obs_be.delete();
        obs_we.delete();
    endtask

    initial begin
        int acc;
        int rc0;
        rst_i         = 1'b1;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = 32'h0;
        iomem_wstrb_i = 16'h0;
        iomem_wdata_i = 128'd0;
        bus_ready_i   = 1'b0;
        bus_rdata_i   = 32'h0;
        model_buf     = 128'd0;
        @(posedge clk);
        #1;
        // Still in reset with valid high: nothing may be accepted, outputs zero.
        idle();
        rst_i = 1'b0;

        // Read of four words from an unaligned address.
        clear_obs();
        run_req(32'h8000_0014, 16'h0000, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 0, 0, 0, 0,
                128'h44444444_33333333_22222222_11111111, -1, acc);
        chk("read_latency", 128'(ready_cyc - acc), 128'd5);
        chk("read_rdata", iomem_rdata_o, 128'h44444444_33333333_22222222_11111111);
        chk("read_nbeats", 128'(obs_addr.size()), 128'd4);
        if (obs_addr.size() == 4) begin
            chk("read_addr0", {96'd0, obs_addr[0]}, {96'd0, 32'h8000_0010});
            chk("read_addr1", {96'd0, obs_addr[1]}, {96'd0, 32'h8000_0014});
            chk("read_addr2", {96'd0, obs_addr[2]}, {96'd0, 32'h8000_0018});
            chk("read_addr3", {96'd0, obs_addr[3]}, {96'd0, 32'h8000_001C});
        end
        idle();

        // Write touching only word 1.
        clear_obs();
        run_req(32'h8000_0000, 16'h00F0, 128'h00000000_00000000_DEADBEEF_00000000, 0, 0, 0, 0,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, -1, acc);
        chk("wr1_latency", 128'(ready_cyc - acc), 128'd5);
        chk("wr1_nbeats", 128'(obs_addr.size()), 128'd1);
        if (obs_addr.size() == 1) begin
            chk("wr1_addr", {96'd0, obs_addr[0]}, {96'd0, 32'h8000_0004});
            chk("wr1_be", {124'd0, obs_be[0]}, {124'd0, 4'hF});
            chk("wr1_we", {127'd0, obs_we[0]}, {127'd0, 1'b1});
            chk("wr1_data", {96'd0, obs_wdata[0]}, {96'd0, 32'hDEAD_BEEF});
        end
        chk("wr1_rdata_kept", iomem_rdata_o, 128'h44444444_33333333_22222222_11111111);
        idle();

        // Read with a three-cycle stall on beat 2.
        run_req(32'h1234_5670, 16'h0000, 128'd0, 0, 0, 3, 0,
                128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, -1, acc);
        chk("stall_latency", 128'(ready_cyc - acc), 128'd8);
        chk("stall_rdata", iomem_rdata_o, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        idle();

        // Reset during beat 1 of a read aborts without a ready pulse.
        rc0 = ready_cnt;
        run_req(32'h0000_0100, 16'h0000, 128'd0, 0, 0, 0, 0,
                128'h55555555_66666666_77777777_88888888, 1, acc);
        idle();
        idle();
        chk("abort_no_ready", 128'(ready_cnt - rc0), 128'd0);
        chk("abort_rdata", iomem_rdata_o, 128'd0);

        // Back-to-back: valid dropped one cycle after ready, then a new request.
        rc0 = ready_cnt;
        run_req(32'h0000_2000, 16'h0000, 128'd0, 1, 0, 0, 2,
                128'h01020304_05060708_090A0B0C_0D0E0F10, -1, acc);
        idle();
        run_req(32'h0000_3008, 16'h0F00, 128'h11112222_33334444_55556666_77778888, 0, 0, 1, 0,
                128'd0, -1, acc);
        chk("b2b_latency2", 128'(ready_cyc - acc), 128'd6);
        chk("b2b_ready_count", 128'(ready_cnt - rc0), 128'd2);
        chk("b2b_rdata", iomem_rdata_o, 128'h01020304_05060708_090A0B0C_0D0E0F10);
        idle();

        // Write with strobes only on words 0 and 3.
        clear_obs();
        run_req(32'h4000_0040, 16'hF00F, 128'hCAFEF00D_22222222_33333333_0BADC0DE, 0, 0, 0, 0,
                128'd0, -1, acc);
        chk("wr2_latency", 128'(ready_cyc - acc), 128'd5);
        chk("wr2_nbeats", 128'(obs_addr.size()), 128'd2);
        if (obs_addr.size() == 2) begin
            chk("wr2_addr0", {96'd0, obs_addr[0]}, {96'd0, 32'h4000_0040});
            chk("wr2_data0", {96'd0, obs_wdata[0]}, {96'd0, 32'h0BAD_C0DE});
            chk("wr2_addr3", {96'd0, obs_addr[1]}, {96'd0, 32'h4000_004C});
            chk("wr2_data3", {96'd0, obs_wdata[1]}, {96'd0, 32'hCAFE_F00D});
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_width_bridge.md
IOMEM_WIDTH_BRIDGE -- requirements
Module: iomem_width_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, address and bus-word width.
REQ-002 SHALL have parameter BLK_SIZE, default 128, cache-block width on the upstream side.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port iomem_valid_i, input, 1, block request valid from the core memory port.
REQ-007 SHALL have port iomem_ready_o, output, 1, one-cycle request-complete pulse.
REQ-008 SHALL have port iomem_addr_i, input, XLEN, block address.
REQ-009 SHALL have port iomem_wstrb_i, input, 16, byte strobes; all-zero means read.
REQ-010 SHALL have port iomem_wdata_i, input, BLK_SIZE, write block.
REQ-011 SHALL have port iomem_rdata_o, output, BLK_SIZE, read block.
REQ-012 SHALL have port bus_valid_o, input/output direction output, 1, word-beat request valid.
REQ-013 SHALL have port bus_ready_i, input, 1, beat accepted; read data valid in the same cycle.
REQ-014 SHALL have port bus_we_o, output, 1, beat is a write.
REQ-015 SHALL have port bus_be_o, output, 4, beat byte enables.
REQ-016 SHALL have port bus_addr_o, output, XLEN, beat word address.
REQ-017 SHALL have port bus_wdata_o, output, XLEN, beat write data.
REQ-018 SHALL have port bus_rdata_i, input, XLEN, beat read data.

Function
REQ-019 SHALL implement FSM states IDLE, BEAT, DONE, with a 2-bit beat counter.
REQ-020 In IDLE with iomem_valid_i=1, SHALL latch addr, wstrb and wdata, clear the beat counter, and enter BEAT on the next cycle.
REQ-021 SHALL set the latched write flag to the OR of all wstrb bits.
REQ-022 SHALL ignore upstream input changes after latching until the next IDLE.
REQ-023 In BEAT, bus_addr_o SHALL be {addr[XLEN-1:4], beat, 2'b00}, regardless of the input addr[3:0].
REQ-024 In BEAT, bus_be_o SHALL be wstrb[4*beat+:4] for writes and 4'hF for reads.
REQ-025 In BEAT, bus_wdata_o SHALL be wdata[32*beat+:32], and bus_we_o SHALL be the write flag.
REQ-026 bus_valid_o SHALL be 1 in BEAT, except on a write beat whose bus_be_o is 0.
REQ-027 A write beat whose bus_be_o is 0 SHALL be skipped, taking exactly one cycle with bus_valid_o=0.
REQ-028 A beat SHALL complete on bus_valid_o and bus_ready_i both high, or on a skip.
REQ-029 When a beat completes, the bridge SHALL advance the counter, or enter DONE if beat is 3.
REQ-030 While bus_valid_o=1 and bus_ready_i=0, all bus_* outputs SHALL hold stable.
REQ-031 On a completing read beat, the bridge SHALL store bus_rdata_i into rdata_buf[32*beat+:32].
REQ-032 A write SHALL leave rdata_buf unchanged.
REQ-033 In DONE, iomem_ready_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-034 iomem_rdata_o SHALL equal rdata_buf continuously and hold until the next read's beats overwrite it.
REQ-035 Upstream SHALL deassert iomem_valid_i in the cycle after iomem_ready_o; valid still high in IDLE SHALL be treated as a new request.
REQ-036 With zero-wait bus, the latency from the accepting IDLE cycle N to the iomem_ready_o pulse SHALL be 5 cycles, at cycle N+5.
REQ-037 Each bus wait cycle SHALL add exactly one cycle of latency.
REQ-038 Outside BEAT, bus_valid_o, bus_we_o, bus_be_o, bus_addr_o and bus_wdata_o SHALL be 0.
REQ-039 bus_ready_i SHALL be ignored when bus_valid_o=0.

Reset
REQ-040 On rst_i=1 at a clock edge, the FSM SHALL enter IDLE, the beat counter SHALL clear, and rdata_buf SHALL clear to 0.
REQ-041 After reset, all outputs SHALL be 0.
REQ-042 Reset mid-transaction SHALL abort with no iomem_ready_o pulse, and bus_valid_o SHALL be 0 from the next cycle.
REQ-043 A request with iomem_valid_i high during reset SHALL NOT be accepted until the first IDLE cycle after rst_i falls.

Verification
REQ-044 Read, addr=0x8000_0014, wstrb=0, bus always ready, rdata per beat 0x11111111/0x22222222/0x33333333/0x44444444 -> bus_addr_o 0x8000_0010/14/18/1C, iomem_ready_o at N+5, iomem_rdata_o=0x44444444_33333333_22222222_11111111.
REQ-045 Write, wstrb=16'h00F0, wdata word1=0xDEADBEEF -> exactly one bus beat: addr base+4, be=4'hF, we=1, data 0xDEADBEEF; iomem_ready_o at N+5; iomem_rdata_o unchanged.
REQ-046 Read with bus_ready_i low 3 cycles on beat 2 -> bus_* stable during the stall, iomem_ready_o at N+8.
REQ-047 Assert rst_i during beat 1 of a read -> no ready pulse, bus_valid_o=0 next cycle, iomem_rdata_o=0.
REQ-048 Back-to-back: valid dropped after ready, reasserted 1 cycle later -> second request accepted, exactly one ready pulse per request.
REQ-049 Write with wstrb=16'hF00F -> beats 0 and 3 issued; beats 1 and 2 skipped with bus_valid_o=0.
